if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Fetch stage and IF/ID pipeline register directly upstream of the hazard unit. Owns the PC,
//  drives a synchronous-read instruction memory (1-cycle latency), and registers {pc,instr,valid}
//  into IF/ID. Consumes hazard pc_write/if_id_write to stall and EX redirect to flush.
//  Exports IF/ID rs/rt fields to the hazard unit. A hold buffer keeps the in-flight imem word
//  across stalls.
// PARAMETERS
//  XLEN      16        PC/address width
//  ILEN      16        instruction width; PC increment = ILEN/8
//  RESET_PC  16'h0000  PC after reset
//  NOP_INSTR 16'h0000  encoding injected as a bubble
//  RS_LSB    4         LSB of 4-bit rs field in instr
//  RT_LSB    0         LSB of 4-bit rt field in instr
// PORTS
//  clk            in   1     single clock, rising edge
//  rst            in   1     synchronous, active-high reset
//  pc_write       in   1     from hazard: 1=advance PC
//  if_id_write    in   1     from hazard: 1=load IF/ID
//  redirect_valid in   1     from EX: taken branch/jump/jr, flush IF/ID
//  redirect_pc    in   XLEN  redirect target
//  imem_addr      out  XLEN  address to sync imem (= pc_q)
//  imem_rdata     in   ILEN  word for address presented previous cycle
//  if_id_pc       out  XLEN  PC of IF/ID instr
//  if_id_instr    out  ILEN  IF/ID instr (NOP_INSTR when invalid)
//  if_id_valid    out  1     IF/ID holds a real instruction
//  if_id_rs       out  4     if_id_instr[RS_LSB+:4]
//  if_id_rt       out  4     if_id_instr[RT_LSB+:4]
// BEHAVIOUR
//  State: pc_q; rsp_valid_q/rsp_pc_q (imem_rdata is valid for rsp_pc_q); hold_valid_q/
//   hold_instr_q/hold_pc_q. Modes: EMPTY(rsp=0,hold=0), STREAM(rsp=1,hold=0), HELD(hold=1).
//  Candidate = HELD ? hold : STREAM ? {rsp_pc_q,imem_rdata,1} : {0,NOP_INSTR,0}.
//  advance = pc_write & if_id_write. Mismatched pair treated as stall (assertion fires).
//  Priority per edge: rst > redirect_valid > advance > stall.
//  rst: pc_q=RESET_PC; rsp_valid_q=0; hold_valid_q=0; if_id_valid=0, if_id_instr=NOP_INSTR,
//   if_id_pc=0. First valid IF/ID word appears 2 edges after rst deasserts (fill latency 2).
//  redirect: pc_q=redirect_pc with bit0 forced 0; rsp_valid_q=0; hold_valid_q=0; IF/ID<=bubble,
//   even if if_id_write=0 (redirect beats stall; stalled ID instr is younger and is squashed).
//  advance: IF/ID<=candidate; rsp_pc_q=pc_q; rsp_valid_q=1; pc_q=pc_q+ILEN/8 (wraps mod 2^XLEN);
//   hold_valid_q=0.
//  stall: pc_q, IF/ID unchanged. If STREAM: hold<=imem_rdata/rsp_pc_q, hold_valid_q=1,
//   rsp_valid_q=0. If HELD or EMPTY: no change. Multi-cycle stalls never lose or duplicate
//   words. imem keeps reading pc_q, so STREAM resumes at pc_q after release.
//  Bubbles (EMPTY) are never marked valid. rs/rt of a bubble decode NOP_INSTR fields.
//  No combinational path from pc_write/if_id_write/redirect to any output.
//  Throughput 1 instr/cycle with no stalls and no redirects.
// STRUCTURE
//  cpu_pkg: XLEN, ILEN, NOP_INSTR, RS_LSB/RT_LSB, REG_ID_W=4, RESET_PC shared with decode/hazard.
//  Sub-module if_hold_buf: 1-entry capture/replay register (capture, clear, valid, data, pc);
//   pc/IF/ID logic stays in if_stage.
// TESTING
//  1 Reset then free-run, imem[a]=a^16'hA5A5 -> imem_addr 0,2,4,...; if_id_valid rises 2 edges
//    after rst low; if_id_pc 0,2,4 in order.
//  2 Stall 3 cycles (pc_write=if_id_write=0) mid-stream -> IF/ID frozen; after release
//    instrs continue with no gap and no duplicate; imem_addr constant during stall.
//  3 redirect_valid=1, redirect_pc=16'h0041 same cycle as stall -> IF/ID bubble next edge,
//    imem_addr=16'h0040, next valid if_id_pc=16'h0040.
//  4 Stall starting on the first cycle after a redirect (EMPTY) -> bubbles only; resume
//    fetches 16'h0040 correctly.
//  5 pc_q=16'hFFFE, advance -> imem_addr=16'h0000 next, if_id_pc=16'hFFFE then 16'h0000.
//  6 rst during a HELD stall -> all outputs to reset values next edge; hold discarded; refill
//    from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared CPU front-end constants (widths, reset PC, bubble encoding,
//           register-id field positions) and the fetch-mode encoding used by
//           the fetch stage. Decode and hazard logic use the same constants.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int          XLEN      = 16;
  localparam int          ILEN      = 16;
  localparam int          REG_ID_W  = 4;
  localparam int          RS_LSB    = 4;
  localparam int          RT_LSB    = 0;
  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Where the next IF/ID word comes from:
  //   EMPTY  : nothing in flight, a bubble is injected
  //   STREAM : imem_rdata is the word for the previously presented address
  //   HELD   : a word was parked in the hold buffer during a stall
  typedef enum logic [1:0] {
    MODE_EMPTY  = 2'd0,
    MODE_STREAM = 2'd1,
    MODE_HELD   = 2'd2
  } fetch_mode_e;

endpackage

`default_nettype wire

// File: rtl/if_hold_buf.sv
// ============================================================================
// Module  : if_hold_buf
// Purpose : One-entry capture/replay register. Parks the in-flight imem word
//           and its PC while the fetch stage is stalled so the word is not
//           lost when imem moves on.
// Ports   : clk, rst         - clock, synchronous active-high reset
//           capture_i        - load data_i/pc_i and mark valid
//           clear_i          - drop the entry (wins over capture_i)
//           data_i, pc_i     - word and its PC to capture
//           valid_o          - entry holds a word
//           data_o, pc_o     - captured word and PC
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_hold_buf
  import cpu_pkg::*;
#(
  parameter int DW = ILEN,
  parameter int AW = XLEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture_i,
  input  logic          clear_i,
  input  logic [DW-1:0] data_i,
  input  logic [AW-1:0] pc_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [AW-1:0] pc_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q,  data_d;
  logic [AW-1:0] pc_q,    pc_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (capture_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module  : if_stage
// Purpose : Instruction fetch stage plus IF/ID pipeline register. Owns the PC,
//           drives a synchronous-read imem (1-cycle latency) and registers
//           {pc, instr, valid} into IF/ID. Stalls on hazard requests, flushes
//           on EX redirects, and parks the in-flight imem word across stalls.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           pc_write_i          - hazard: advance the PC
//           if_id_write_i       - hazard: load IF/ID
//           redirect_valid_i    - EX: taken branch/jump, flush IF/ID
//           redirect_pc_i       - EX: redirect target
//           imem_addr_o         - imem address (current PC)
//           imem_rdata_i        - imem word for last cycle's address
//           if_id_pc_o          - PC of the IF/ID instruction
//           if_id_instr_o       - IF/ID instruction (NOP_INSTR when invalid)
//           if_id_valid_o       - IF/ID holds a real instruction
//           if_id_rs_o/_rt_o    - register-id fields of the IF/ID instruction
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
  parameter int              XLEN      = 16,
  parameter int              ILEN      = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [ILEN-1:0] NOP_INSTR = '0,
  parameter int              RS_LSB    = 4,
  parameter int              RT_LSB    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write_i,
  input  logic            if_id_write_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [ILEN-1:0] if_id_instr_o,
  output logic            if_id_valid_o,
  output logic [3:0]      if_id_rs_o,
  output logic [3:0]      if_id_rt_o
);

  import cpu_pkg::*;

  localparam logic [XLEN-1:0] PC_INC = XLEN'(ILEN / 8);

  // PC and imem response tracking
  logic [XLEN-1:0] pc_q, pc_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;

  // IF/ID register
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [ILEN-1:0] if_id_instr_q, if_id_instr_d;
  logic            if_id_valid_q, if_id_valid_d;

  // Hold buffer interface
  logic            hold_capture, hold_clear, hold_valid;
  logic [ILEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;

  logic            advance;
  fetch_mode_e     mode;
  logic [XLEN-1:0] cand_pc;
  logic [ILEN-1:0] cand_instr;
  logic            cand_valid;

  if_hold_buf #(
    .DW (ILEN),
    .AW (XLEN)
  ) u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .capture_i (hold_capture),
    .clear_i   (hold_clear),
    .data_i    (imem_rdata_i),
    .pc_i      (rsp_pc_q),
    .valid_o   (hold_valid),
    .data_o    (hold_instr),
    .pc_o      (hold_pc)
  );

  // A mismatched pc_write/if_id_write pair is treated as a stall.
  assign advance = pc_write_i & if_id_write_i;

  always_comb begin
    mode = MODE_EMPTY;
    if (hold_valid)       mode = MODE_HELD;
    else if (rsp_valid_q) mode = MODE_STREAM;
  end

  always_comb begin
    cand_pc    = '0;
    cand_instr = NOP_INSTR;
    cand_valid = 1'b0;
    case (mode)
      MODE_HELD: begin
        cand_pc    = hold_pc;
        cand_instr = hold_instr;
        cand_valid = 1'b1;
      end
      MODE_STREAM: begin
        cand_pc    = rsp_pc_q;
        cand_instr = imem_rdata_i;
        cand_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_pc_d      = rsp_pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    hold_capture  = 1'b0;
    hold_clear    = 1'b0;

    if (redirect_valid_i) begin
      // Redirect beats a stall: the stalled ID instruction is younger than
      // the redirecting one and must be squashed.
      pc_d          = redirect_pc_i & ~XLEN'(1);
      rsp_valid_d   = 1'b0;
      hold_clear    = 1'b1;
      if_id_pc_d    = '0;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end else if (advance) begin
      if_id_pc_d    = cand_pc;
      if_id_instr_d = cand_instr;
      if_id_valid_d = cand_valid;
      rsp_pc_d      = pc_q;
      rsp_valid_d   = 1'b1;
      pc_d          = pc_q + PC_INC;
      hold_clear    = 1'b1;
    end else if (mode == MODE_STREAM) begin
      // imem will keep reading pc_q during the stall, so the word currently
      // on imem_rdata must be parked or it is lost.
      hold_capture  = 1'b1;
      rsp_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      rsp_valid_q   <= 1'b0;
      rsp_pc_q      <= '0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_pc_q      <= rsp_pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_valid_o = if_id_valid_q;
  assign if_id_rs_o    = if_id_instr_q[RS_LSB +: 4];
  assign if_id_rt_o    = if_id_instr_q[RT_LSB +: 4];

  a_hazard_pair: assert property (@(posedge clk) disable iff (rst || redirect_valid_i)
                                  (pc_write_i == if_id_write_i));

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module  : tb_if_stage
// Purpose : Self-checking bench for if_stage. The reference model tracks the
//           fetch stream as (base address, number of advances since the last
//           reset/redirect): the k-th advance delivers the word at
//           base + 2*(k-2) (bubbles for k < 2), and the fetch address is
//           base + 2*k.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, if_id_write, redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr, imem_rdata;
  logic [15:0] if_id_pc, if_id_instr;
  logic        if_id_valid;
  logic [3:0]  if_id_rs, if_id_rt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_base;
  int          m_k;
  logic [15:0] e_pc, e_instr;
  logic        e_valid;

  always #5 clk = ~clk;

  if_stage dut (
    .clk              (clk),
    .rst              (rst),
    .pc_write_i       (pc_write),
    .if_id_write_i    (if_id_write),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem_addr_o      (imem_addr),
    .imem_rdata_i     (imem_rdata),
    .if_id_pc_o       (if_id_pc),
    .if_id_instr_o    (if_id_instr),
    .if_id_valid_o    (if_id_valid),
    .if_id_rs_o       (if_id_rs),
    .if_id_rt_o       (if_id_rt)
  );

  // Synchronous-read instruction memory
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  function automatic logic [56:0] obs_vec();
    return {imem_addr, if_id_pc, if_id_instr, if_id_valid, if_id_rs, if_id_rt};
  endfunction

  function automatic logic [56:0] exp_vec();
    logic [15:0] a;
    a = m_base + 16'(2 * m_k);
    return {a, e_pc, e_instr, e_valid, e_instr[7:4], e_instr[3:0]};
  endfunction

  task automatic set_bubble();
    e_pc    = 16'h0000;
    e_instr = 16'h0000;
    e_valid = 1'b0;
  endtask

  // Drive one cycle and advance the reference model for that edge.
  task automatic step(input logic r, input logic adv, input logic rv, input logic [15:0] rpc);
    rst            = r;
    pc_write       = adv;
    if_id_write    = adv;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
    if (r) begin
      m_base = 16'h0000;
      m_k    = 0;
      set_bubble();
    end else if (rv) begin
      m_base = {rpc[15:1], 1'b0};
      m_k    = 0;
      set_bubble();
    end else if (adv) begin
      m_k = m_k + 1;
      if (m_k >= 2) begin
        e_pc    = m_base + 16'(2 * (m_k - 2));
        e_instr = mem_word(e_pc);
        e_valid = 1'b1;
      end else begin
        set_bubble();
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs_vec(), exp_vec());
    end
    checks++;
    if ({imem_addr, if_id_valid, if_id_instr, if_id_pc} !== {16'h0000, 1'b0, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL reset_values: got addr=%h v=%b instr=%h pc=%h want 0000 0 0000 0000",
               imem_addr, if_id_valid, if_id_instr, if_id_pc);
    end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL free_run[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        checks++;
        if ({if_id_valid, if_id_pc} !== {1'b1, 16'h0000}) begin
          errors++;
          $display("FAIL fill_latency: got v=%b pc=%h want v=1 pc=0000", if_id_valid, if_id_pc);
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, !(i >= 3 && i < 6), 1'b0, 16'h0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stall[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_redirect_stall();
    step(1'b0, 1'b0, 1'b1, 16'h0041);
    checks++;
    if ({imem_addr, if_id_valid} !== {16'h0040, 1'b0}) begin
      errors++;
      $display("FAIL redirect_flush: got addr=%h v=%b want addr=0040 v=0", imem_addr, if_id_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL redirect_refill[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        checks++;
        if ({if_id_valid, if_id_pc} !== {1'b1, 16'h0040}) begin
          errors++;
          $display("FAIL redirect_target: got v=%b pc=%h want v=1 pc=0040", if_id_valid, if_id_pc);
        end
      end
    end
  endtask

  task automatic test_stall_after_redirect();
    step(1'b0, 1'b1, 1'b1, 16'h0041);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, (i >= 3), 1'b0, 16'h0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL stall_after_redirect[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, 1'b1, 16'hFFFE);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    checks++;
    if (imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_addr: got %h want 0000", imem_addr);
    end
    step(1'b0, 1'b1, 1'b0, 16'h0);
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 16'hFFFE, 16'hFFFE ^ 16'hA5A5}) begin
      errors++;
      $display("FAIL wrap_last: got v=%b pc=%h instr=%h want v=1 pc=fffe", if_id_valid, if_id_pc, if_id_instr);
    end
    step(1'b0, 1'b1, 1'b0, 16'h0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL wrap_first: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_during_hold();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_in_hold: got %h want %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_refill[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int          r;
    logic [15:0] tgt;
    for (int i = 0; i < 400; i++) begin
      r   = int'($urandom_range(0, 99));
      tgt = 16'($urandom);
      if (r < 2)       step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 16'h0);
      else if (r < 8)  step(1'b0, 1'($urandom_range(0, 1)), 1'b1, tgt);
      else if (r < 40) step(1'b0, 1'b0, 1'b0, tgt);
      else             step(1'b0, 1'b1, 1'b0, tgt);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    pc_write       = 1'b0;
    if_id_write    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    m_base         = 16'h0;
    m_k            = 0;
    set_bubble();

    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_stall_after_redirect();
    test_wrap();
    test_reset_during_hold();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no completion want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
